// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state encodings for the serial frame blocks
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out framer with ready/valid load and stallable shift
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_count;
    logic             r_done;
    logic             w_last;
    logic             w_accept;
    logic             w_head;

    assign w_last   = (r_state == ST_SHIFT) && (r_count == LAST) && shift_en;
    assign w_accept = load_valid && load_ready;

    always_comb begin
        w_state_nxt = r_state;
        load_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A new word may only slip in while the final bit is being consumed.
                load_ready = w_last;
                if (w_last && !load_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if (w_accept) begin
                r_shreg <= load_data;
                r_count <= '0;
            end else if ((r_state == ST_SHIFT) && shift_en) begin
                if (MSB_FIRST != 0) begin
                    r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                end else begin
                    r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                end
                if (r_count != LAST) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign w_head     = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];
    assign sout       = (r_state == ST_SHIFT) ? w_head : 1'b0;
    assign sout_valid = (r_state == ST_SHIFT);
    assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized and directed bench with a bit-queue reference model
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       shift_en = 1'b1;
    logic       sout, sout_valid, load_ready, done;
    logic       sout_l, sout_valid_l, load_ready_l, done_l;

    int vecs = 0;
    int errs = 0;

    bit qm[$];
    bit ql[$];
    bit m_done = 1'b0;
    logic e_sout, e_sout_l, e_valid, e_ready, e_done;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .shift_en(shift_en), .sout(sout),
        .sout_valid(sout_valid), .done(done)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_l),
        .load_data(load_data), .shift_en(shift_en), .sout(sout_l),
        .sout_valid(sout_valid_l), .done(done_l)
    );

    // Reference: a frame is a queue of bits still to be consumed.
    task automatic model_advance();
        bit acc, last;
        if (reset) begin
            qm.delete();
            ql.delete();
            m_done = 1'b0;
            return;
        end
        acc  = load_valid && (qm.size() == 0 || (qm.size() == 1 && shift_en));
        last = (qm.size() == 1) && shift_en;
        if (shift_en && qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        m_done = last;
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                qm.push_back(load_data[7-i]);
                ql.push_back(load_data[i]);
            end
        end
    endtask

    task automatic predict();
        e_valid  = (qm.size() != 0);
        e_sout   = e_valid ? qm[0] : 1'b0;
        e_sout_l = e_valid ? ql[0] : 1'b0;
        e_ready  = (qm.size() == 0) || (qm.size() == 1 && shift_en);
        e_done   = m_done;
    endtask

    task automatic apply(input bit rst, input bit lv, input logic [7:0] ld, input bit se);
        @(posedge clk);
        model_advance();
        @(negedge clk);
        reset      = rst;
        load_valid = lv;
        load_data  = ld;
        shift_en   = se;
        #1;
        predict();
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 8'h00, 1'b1);
        apply(1'b1, 1'b1, 8'hFF, 1'b1);
        apply(1'b0, 1'b0, 8'h00, 1'b1);
        vecs++;
        if ({sout, sout_valid, load_ready, done, sout_l, sout_valid_l, load_ready_l, done_l} !== 8'b0010_0010) begin
            errs++;
            $display("FAIL reset_state got %b exp 00100010",
                     {sout, sout_valid, load_ready, done, sout_l, sout_valid_l, load_ready_l, done_l});
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] w = 8'hB3;
        for (int k = 0; k <= 11; k++) begin
            apply(1'b0, k == 0, w, 1'b1);
            vecs++;
            if ({sout, sout_valid, load_ready, done, sout_l} !== {e_sout, e_valid, e_ready, e_done, e_sout_l}) begin
                errs++;
                $display("FAIL basic_model k=%0d got %b exp %b", k,
                         {sout, sout_valid, load_ready, done, sout_l}, {e_sout, e_valid, e_ready, e_done, e_sout_l});
            end
            if (k >= 1 && k <= 8) begin
                vecs++;
                if ({sout_valid, sout} !== {1'b1, w[8-k]}) begin
                    errs++;
                    $display("FAIL basic_bit k=%0d got %b exp %b", k, {sout_valid, sout}, {1'b1, w[8-k]});
                end
            end
            vecs++;
            if (done !== (k == 9)) begin
                errs++;
                $display("FAIL basic_done k=%0d got %b exp %b", k, done, (k == 9));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= 19; k++) begin
            apply(1'b0, k <= 8, (k == 0) ? 8'hFF : 8'h00, 1'b1);
            vecs++;
            if ({sout, sout_valid, load_ready, done, sout_l} !== {e_sout, e_valid, e_ready, e_done, e_sout_l}) begin
                errs++;
                $display("FAIL b2b_model k=%0d got %b exp %b", k,
                         {sout, sout_valid, load_ready, done, sout_l}, {e_sout, e_valid, e_ready, e_done, e_sout_l});
            end
            if (k >= 1 && k <= 16) begin
                vecs++;
                if ({sout_valid, sout} !== {1'b1, k <= 8}) begin
                    errs++;
                    $display("FAIL b2b_bit k=%0d got %b exp %b", k, {sout_valid, sout}, {1'b1, k <= 8});
                end
            end
            vecs++;
            if (done !== (k == 9 || k == 17)) begin
                errs++;
                $display("FAIL b2b_done k=%0d got %b exp %b", k, done, (k == 9 || k == 17));
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] w = 8'hA5;
        int idx;
        for (int k = 0; k <= 14; k++) begin
            apply(1'b0, k == 0, w, !(k >= 4 && k <= 6));
            vecs++;
            if ({sout, sout_valid, load_ready, done, sout_l} !== {e_sout, e_valid, e_ready, e_done, e_sout_l}) begin
                errs++;
                $display("FAIL stall_model k=%0d got %b exp %b", k,
                         {sout, sout_valid, load_ready, done, sout_l}, {e_sout, e_valid, e_ready, e_done, e_sout_l});
            end
            if (k >= 1 && k <= 11) begin
                idx = (k < 4) ? 8 - k : (k <= 7) ? 4 : 11 - k;
                vecs++;
                if ({sout_valid, sout} !== {1'b1, w[idx]}) begin
                    errs++;
                    $display("FAIL stall_bit k=%0d got %b exp %b", k, {sout_valid, sout}, {1'b1, w[idx]});
                end
            end
            vecs++;
            if (done !== (k == 12)) begin
                errs++;
                $display("FAIL stall_done k=%0d got %b exp %b", k, done, (k == 12));
            end
        end
    endtask

    task automatic test_load_busy();
        for (int k = 0; k <= 11; k++) begin
            apply(1'b0, k == 0 || k == 2, (k == 2) ? 8'h3C : 8'h96, 1'b1);
            vecs++;
            if ({sout, sout_valid, load_ready, done, sout_l} !== {e_sout, e_valid, e_ready, e_done, e_sout_l}) begin
                errs++;
                $display("FAIL busy_model k=%0d got %b exp %b", k,
                         {sout, sout_valid, load_ready, done, sout_l}, {e_sout, e_valid, e_ready, e_done, e_sout_l});
            end
            if (k == 2) begin
                vecs++;
                if (load_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL busy_ready got %b exp 0", load_ready);
                end
            end
            if (k == 10) begin
                vecs++;
                if (sout_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL busy_extra_frame got valid %b exp 0", sout_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k <= 12; k++) begin
            apply(k == 5, k == 0, 8'hE7, 1'b1);
            vecs++;
            if ({sout, sout_valid, load_ready, done, sout_l} !== {e_sout, e_valid, e_ready, e_done, e_sout_l}) begin
                errs++;
                $display("FAIL rstmid_model k=%0d got %b exp %b", k,
                         {sout, sout_valid, load_ready, done, sout_l}, {e_sout, e_valid, e_ready, e_done, e_sout_l});
            end
            if (k >= 6) begin
                vecs++;
                if ({sout, sout_valid, load_ready, done} !== 4'b0010) begin
                    errs++;
                    $display("FAIL rstmid_idle k=%0d got %b exp 0010", k, {sout, sout_valid, load_ready, done});
                end
            end
        end
    endtask

    task automatic test_lsb_first();
        for (int k = 0; k <= 10; k++) begin
            apply(1'b0, k == 0, 8'h01, 1'b1);
            if (k >= 1 && k <= 8) begin
                vecs++;
                if ({sout_valid_l, sout_l, sout} !== {1'b1, k == 1, k == 8}) begin
                    errs++;
                    $display("FAIL lsb_bit k=%0d got %b exp %b", k, {sout_valid_l, sout_l, sout}, {1'b1, k == 1, k == 8});
                end
            end
            vecs++;
            if ({done_l, load_ready_l} !== {k == 9, e_ready}) begin
                errs++;
                $display("FAIL lsb_ctrl k=%0d got %b exp %b", k, {done_l, load_ready_l}, {k == 9, e_ready});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            apply($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0);
            vecs++;
            if ({sout, sout_valid, load_ready, done, sout_l, sout_valid_l, load_ready_l, done_l} !==
                {e_sout, e_valid, e_ready, e_done, e_sout_l, e_valid, e_ready, e_done}) begin
                errs++;
                $display("FAIL random k=%0d got %b exp %b", k,
                         {sout, sout_valid, load_ready, done, sout_l, sout_valid_l, load_ready_l, done_l},
                         {e_sout, e_valid, e_ready, e_done, e_sout_l, e_valid, e_ready, e_done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_stall();
        test_load_busy();
        test_reset_mid_frame();
        test_lsb_first();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per parallel word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = word bit WIDTH-1 is sent first and 0 = bit 0 is sent first.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_valid  input  1  upstream has a word on load_data.
REQ-006 SHALL have port load_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port load_data  input  WIDTH  parallel word to serialize.
REQ-008 SHALL have port shift_en  input  1  downstream consumes the current bit this cycle; 0 = stall.
REQ-009 SHALL have port sout  output  1  serial bit that feeds the downstream detector's din.
REQ-010 SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-012 SHALL implement two states: IDLE and SHIFT.
REQ-013 SHALL drive load_ready = 1 when in IDLE, or when in SHIFT with bit count = WIDTH-1 and shift_en = 1; load_ready SHALL be 0 otherwise.
REQ-014 SHALL accept a word only in a cycle with load_valid = 1 and load_ready = 1; load_valid while load_ready = 0 SHALL be ignored, and no word is captured.
REQ-015 SHALL, on acceptance in cycle N, load the shift register, clear the bit count to 0, and enter SHIFT so that the first frame bit appears on sout in cycle N+1.
REQ-016 SHALL hold sout_valid = 1 in every SHIFT cycle and 0 in IDLE.
REQ-017 SHALL, in IDLE, drive sout = 0.
REQ-018 SHALL, in a SHIFT cycle with shift_en = 1 and count < WIDTH-1, advance to the next bit and increment count.
REQ-019 SHALL, in a SHIFT cycle with shift_en = 0, hold sout, the count and the shift register unchanged.
REQ-020 SHALL treat a SHIFT cycle with count = WIDTH-1 and shift_en = 1 as the last-bit consumption cycle, with the next state as follows:
  - if a new word is accepted in the same cycle: reload and stay in SHIFT, with no idle gap;
  - otherwise: go to IDLE.
REQ-021 SHALL assert done as a registered pulse in the single cycle following each last-bit consumption cycle, including back-to-back frames.
REQ-022 SHALL, with a stall (shift_en = 0) on the last bit, keep load_ready = 0 until shift_en returns to 1.
REQ-023 SHALL give a frame latency of WIDTH + S cycles from the acceptance cycle to the last-bit consumption cycle, where S = number of stall cycles.

Reset
REQ-024 SHALL, on reset = 1 at a clock edge, force state = IDLE, shift register = 0, count = 0, sout = 0, sout_valid = 0 and done = 0; load_ready SHALL then be 1 from the next cycle.
REQ-025 SHALL give reset priority over load acceptance and shifting in the same cycle.
REQ-026 SHALL abandon a frame in progress on reset without emitting done.

Structure
REQ-027 SHALL place the state encodings (ST_IDLE, ST_SHIFT) in the shared package used by the serial-detector blocks.
REQ-028 SHALL be a single module with the count, shift register and state inline; no sub-module is needed.
REQ-029 SHALL size the count as clog2(WIDTH) bits.

Verification
REQ-030 SHALL cover a basic frame: WIDTH=8, MSB_FIRST=1, load 8'b1011_0011 at cycle N with shift_en held at 1 -> sout = 1,0,1,1,0,0,1,1 in cycles N+1..N+8 with sout_valid = 1, and done = 1 only in cycle N+9.
REQ-031 SHALL cover back-to-back frames: 8'hFF, then 8'h00 offered with load_valid held at 1 -> 16 contiguous valid bits (eight 1s, then eight 0s), no sout_valid gap, and done pulses at N+9 and N+17.
REQ-032 SHALL cover a mid-frame stall: load 8'hA5, drive shift_en = 0 for 3 cycles while the 4th bit is presented -> that bit is held for 4 cycles, all 8 bits arrive in order, and done appears at N+12.
REQ-033 SHALL cover reset mid-frame: reset = 1 during the 5th bit -> next cycle sout_valid = 0, sout = 0, load_ready = 1, and no done pulse.
REQ-034 SHALL cover a load while busy: load_valid = 1 with 8'h3C during bit 2 of a frame -> load_ready = 0, the word is ignored, and the current frame completes unchanged.
REQ-035 SHALL cover LSB-first order: MSB_FIRST = 0, load 8'h01 -> sout = 1 followed by seven 0s.
